// File: rtl/sprite_compositor_if.sv
// Signal bundle between the VGA timing generator, the sprite RAMs and the
// palette lookup. The compositor uses the slave view. A driver or bench
// uses the master view.
interface sprite_compositor_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs_in;
    logic        vs_in;
    logic        blank_in;
    logic [8:0]  char_x;
    logic [7:0]  char_y;
    logic [1:0]  dir;
    logic        move_req;
    logic [18:0] map_read_address;
    logic [12:0] char_read_address;
    logic [7:0]  map_data;
    logic [7:0]  char_data;
    logic [7:0]  pixel_index;
    logic        pixel_valid;
    logic        hs_out;
    logic        vs_out;

    modport slave (
        input  DrawX, DrawY, hs_in, vs_in, blank_in,
        input  char_x, char_y, dir, move_req,
        output map_read_address, char_read_address,
        input  map_data, char_data,
        output pixel_index, pixel_valid, hs_out, vs_out
    );

    modport master (
        output DrawX, DrawY, hs_in, vs_in, blank_in,
        output char_x, char_y, dir, move_req,
        input  map_read_address, char_read_address,
        output map_data, char_data,
        input  pixel_index, pixel_valid, hs_out, vs_out
    );
endinterface

// File: rtl/sprite_compositor.sv
// Sprite compositor: this stage turns the draw coordinate into map and
// character RAM addresses. It then overlays the animated character on the 2x
// scaled map and uses colour-key transparency. The result is a palette index
// that arrives three cycles after the coordinate, together with the delayed
// sync and blank signals.
module sprite_compositor #(
    parameter int         MAP_W       = 320,
    parameter int         CHAR_W      = 16,
    parameter int         CHAR_H      = 20,
    parameter int         ANIM_TICKS  = 8,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input logic                Clk,
    input logic                Reset,
    sprite_compositor_if.slave bus
);
    localparam int CW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(ANIM_TICKS - 1);

    typedef enum logic [1:0] {STAND, STEP_L, MID, STEP_R} walk_state_t;

    walk_state_t   state, state_next;
    logic [CW-1:0] tick_count, tick_count_next;

    logic        vs_q;
    logic        frame_tick;
    logic [8:0]  cx_s;
    logic [7:0]  cy_s;
    logic [1:0]  dir_s;
    logic [1:0]  pose;
    logic [3:0]  frame;

    logic [8:0]  mx;
    logic [8:0]  my_full;
    logic [7:0]  my;
    logic [8:0]  dx;
    logic [7:0]  dy;
    logic        in_char_next;
    logic [18:0] map_addr_next;
    logic [12:0] char_addr_next;

    logic        in_char_1, in_char_2;
    logic        hs_1, hs_2, vs_1, vs_2, blank_1, blank_2;
    logic        unused_bits;

    assign mx          = bus.DrawX[9:1];
    assign my_full     = bus.DrawY[9:1];
    assign my          = my_full[7:0];
    assign unused_bits = ^{bus.DrawX[0], bus.DrawY[0]};

    // A frame tick is the first cycle in which vs_in reads low after it was high.
    assign frame_tick = vs_q & ~bus.vs_in;

    // The walk state sets the pose. Each facing direction owns three poses.
    always_comb begin
        pose = 2'd0;
        unique case (state)
            STEP_L:  pose = 2'd1;
            STEP_R:  pose = 2'd2;
            default: pose = 2'd0;
        endcase
        frame = 4'(dir_s) * 4'd3 + 4'(pose);
    end

    // Address datapath. An unsigned subtraction pushes any pixel left of or
    // above the sprite out of range.
    always_comb begin
        dx             = mx - cx_s;
        dy             = my - cy_s;
        in_char_next   = (dx < 9'(CHAR_W)) && (dy < 8'(CHAR_H));
        map_addr_next  = 19'(my_full) * 19'(MAP_W) + 19'(mx);
        char_addr_next = 13'(frame) * 13'(CHAR_W * CHAR_H)
                       + 13'(dy) * 13'(CHAR_W) + 13'(dx);
    end

    // Walk FSM next state. STAND moves off at once. Other states move only when
    // the per-pose tick count expires.
    always_comb begin
        state_next      = state;
        tick_count_next = tick_count;
        if (state == STAND) begin
            tick_count_next = '0;
        end
        if (frame_tick) begin
            if (state == STAND) begin
                if (bus.move_req) begin
                    state_next = STEP_L;
                end
            end else if (tick_count == LAST_TICK) begin
                tick_count_next = '0;
                if (!bus.move_req) begin
                    state_next = STAND;
                end else begin
                    unique case (state)
                        STEP_L:  state_next = MID;
                        MID:     state_next = STEP_R;
                        default: state_next = STAND;
                    endcase
                end
            end else begin
                tick_count_next = tick_count + 1'b1;
            end
        end
    end

    // Once per frame, update the shadow position and walk state so that a sprite never tears mid-frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_q       <= 1'b1;
            state      <= STAND;
            tick_count <= '0;
            cx_s       <= '0;
            cy_s       <= '0;
            dir_s      <= '0;
        end else begin
            vs_q       <= bus.vs_in;
            state      <= state_next;
            tick_count <= tick_count_next;
            if (frame_tick) begin
                cx_s  <= bus.char_x;
                cy_s  <= bus.char_y;
                dir_s <= bus.dir;
            end
        end
    end

    // Stages 1 and 2: register the RAM addresses, then carry in_char and sync/blank while the RAMs read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.map_read_address  <= '0;
            bus.char_read_address <= '0;
            in_char_1             <= 1'b0;
            in_char_2             <= 1'b0;
            hs_1                  <= 1'b1;
            hs_2                  <= 1'b1;
            vs_1                  <= 1'b1;
            vs_2                  <= 1'b1;
            blank_1               <= 1'b0;
            blank_2               <= 1'b0;
        end else begin
            bus.map_read_address  <= map_addr_next;
            bus.char_read_address <= in_char_next ? char_addr_next : '0;
            in_char_1             <= in_char_next;
            in_char_2             <= in_char_1;
            hs_1                  <= bus.hs_in;
            hs_2                  <= hs_1;
            vs_1                  <= bus.vs_in;
            vs_2                  <= vs_1;
            blank_1               <= bus.blank_in;
            blank_2               <= blank_1;
        end
    end

    // Stage 3: overlay the character on the map, blank outside active video, and drive the delayed syncs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.pixel_index <= '0;
            bus.pixel_valid <= 1'b0;
            bus.hs_out      <= 1'b1;
            bus.vs_out      <= 1'b1;
        end else begin
            if (!blank_2) begin
                bus.pixel_index <= '0;
            end else if (in_char_2 && (bus.char_data != TRANSPARENT)) begin
                bus.pixel_index <= bus.char_data;
            end else begin
                bus.pixel_index <= bus.map_data;
            end
            bus.pixel_valid <= blank_2;
            bus.hs_out      <= hs_2;
            bus.vs_out      <= vs_2;
        end
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// Testbench for sprite_compositor. It applies directed pixel vectors and
// frame ticks. Expected palette indices go into a scoreboard queue, and a
// monitor process pops that queue whenever pixel_valid is high.
module tb_sprite_compositor;
    logic clk;
    logic rst;

    sprite_compositor_if bus();

    sprite_compositor #(
        .MAP_W(320), .CHAR_W(16), .CHAR_H(20), .ANIM_TICKS(2), .TRANSPARENT(8'h00)
    ) dut (
        .Clk(clk),
        .Reset(rst),
        .bus(bus)
    );

    int n_applied = 0;
    int n_miscompares = 0;
    logic [7:0] sb[$];

    logic m_h1, m_h2, m_h3, m_v1, m_v2, m_v3, m_b1, m_b2, m_b3;
    logic [7:0] m_exp;

    int walk_char_addr[11] = '{3218, 3218, 2898, 2898, 3538, 3538, 2898, 3218, 3218, 2898, 2898};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Map RAM contents: address 321 holds 2A. Every other byte is {addr[3:0], 3}.
    function automatic logic [7:0] map_val(input logic [18:0] a);
        if (a == 19'd321) return 8'h2A;
        return {a[3:0], 4'h3};
    endfunction

    // Character RAM contents: sprite column 0 is transparent. Every other byte is {1, addr[3:0]}.
    function automatic logic [7:0] char_val(input logic [12:0] a);
        if (a[3:0] == 4'h0) return 8'h00;
        return {4'h1, a[3:0]};
    endfunction

    always @(posedge clk) begin
        bus.map_data  <= map_val(bus.map_read_address);
        bus.char_data <= char_val(bus.char_read_address);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input logic blank,
                                 input int exp_map, input int exp_char, input logic [7:0] exp_pix);
        @(negedge clk);
        bus.DrawX    = 10'(x);
        bus.DrawY    = 10'(y);
        bus.blank_in = blank;
        if (blank) sb.push_back(exp_pix);
        @(posedge clk);
        #1;
        checkOutput("map_read_address", 32'(bus.map_read_address), 32'(exp_map));
        checkOutput("char_read_address", 32'(bus.char_read_address), 32'(exp_char));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.blank_in = 1'b0;
    endtask

    task automatic frameTick();
        @(negedge clk);
        bus.blank_in = 1'b0;
        bus.hs_in    = 1'b0;
        @(negedge clk);
        bus.hs_in = 1'b1;
        bus.vs_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.vs_in = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: a 3-deep delay model of the sync and blank inputs, plus scoreboard popping.
    initial begin
        m_h1 = 1; m_h2 = 1; m_h3 = 1;
        m_v1 = 1; m_v2 = 1; m_v3 = 1;
        m_b1 = 0; m_b2 = 0; m_b3 = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_h1 = 1; m_h2 = 1; m_h3 = 1;
                m_v1 = 1; m_v2 = 1; m_v3 = 1;
                m_b1 = 0; m_b2 = 0; m_b3 = 0;
            end else begin
                m_h3 = m_h2; m_h2 = m_h1; m_h1 = bus.hs_in;
                m_v3 = m_v2; m_v2 = m_v1; m_v1 = bus.vs_in;
                m_b3 = m_b2; m_b2 = m_b1; m_b1 = bus.blank_in;
            end
            #1;
            checkOutput("hs_out", 32'(bus.hs_out), 32'(m_h3));
            checkOutput("vs_out", 32'(bus.vs_out), 32'(m_v3));
            checkOutput("pixel_valid", 32'(bus.pixel_valid), 32'(m_b3));
            if (bus.pixel_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid_pixel", 32'(bus.pixel_index), 32'hFFFF_FFFF);
                end else begin
                    m_exp = sb.pop_front();
                    checkOutput("pixel_index", 32'(bus.pixel_index), 32'(m_exp));
                end
            end else begin
                checkOutput("blanked_pixel_index", 32'(bus.pixel_index), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        rst          = 1'b1;
        bus.DrawX    = '0;
        bus.DrawY    = '0;
        bus.hs_in    = 1'b1;
        bus.vs_in    = 1'b1;
        bus.blank_in = 1'b0;
        bus.char_x   = '0;
        bus.char_y   = '0;
        bus.dir      = '0;
        bus.move_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_map_addr", 32'(bus.map_read_address), 32'd0);
        checkOutput("reset_char_addr", 32'(bus.char_read_address), 32'd0);
        checkOutput("reset_pixel_index", 32'(bus.pixel_index), 32'd0);
        checkOutput("reset_hs_out", 32'(bus.hs_out), 32'd1);
        rst = 1'b0;

        // Latch sprite at (100,50) facing right, standing.
        bus.char_x = 9'd100;
        bus.char_y = 8'd50;
        bus.dir    = 2'd3;
        frameTick();

        applyStimulus(3,   3,   1'b1, 321,   0,    8'h2A);
        applyStimulus(204, 102, 1'b1, 16422, 2898, 8'h12);
        applyStimulus(200, 102, 1'b1, 16420, 2896, 8'h43);
        applyStimulus(198, 102, 1'b1, 16419, 0,    8'h33);
        applyStimulus(230, 102, 1'b1, 16435, 2911, 8'h1F);
        applyStimulus(232, 102, 1'b1, 16436, 0,    8'h43);
        applyStimulus(204, 138, 1'b1, 22182, 3186, 8'h12);
        applyStimulus(204, 140, 1'b1, 22502, 0,    8'h63);
        applyStimulus(639, 479, 1'b1, 76799, 0,    8'hF3);

        // A mid-frame position change waits for the next frame tick.
        bus.char_x = 9'd200;
        applyStimulus(204, 102, 1'b1, 16422, 2898, 8'h12);
        frameTick();
        applyStimulus(204, 102, 1'b1, 16422, 0,    8'h63);
        applyStimulus(404, 102, 1'b1, 16522, 2898, 8'h12);

        // Walk animation with two frames per pose, then move_req drops.
        bus.move_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i == 8) bus.move_req = 1'b0;
            frameTick();
            applyStimulus(404, 102, 1'b1, 16522, walk_char_addr[i], 8'h12);
        end

        // The index is forced to zero outside active video.
        applyStimulus(404, 102, 1'b0, 16522, 2898, 8'h00);
        idle();

        // Assert reset mid-line while the character is walking.
        bus.move_req = 1'b1;
        frameTick();
        applyStimulus(404, 102, 1'b1, 16522, 3218, 8'h12);
        applyStimulus(404, 102, 1'b1, 16522, 3218, 8'h12);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("midreset_map_addr", 32'(bus.map_read_address), 32'd0);
        checkOutput("midreset_char_addr", 32'(bus.char_read_address), 32'd0);
        checkOutput("midreset_pixel_index", 32'(bus.pixel_index), 32'd0);
        checkOutput("midreset_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        checkOutput("midreset_hs_out", 32'(bus.hs_out), 32'd1);
        checkOutput("midreset_vs_out", 32'(bus.vs_out), 32'd1);
        @(negedge clk);
        bus.blank_in = 1'b0;
        bus.move_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // The shadows are back to 0, so (202,51) lies outside the sprite.
        applyStimulus(404, 102, 1'b1, 16522, 0, 8'hA3);
        // The FSM must be in STAND after reset, so the pose is 0.
        bus.char_x = 9'd200;
        bus.char_y = 8'd50;
        bus.dir    = 2'd3;
        frameTick();
        applyStimulus(404, 102, 1'b1, 16522, 2898, 8'h12);

        idle();
        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end
endmodule
